// File: rtl/aged_req_queue_if.sv
// rtl/aged_req_queue_if.sv - request/issue handshake bundle for aged_req_queue
//
// Purpose: groups the upstream push channel, downstream issue channel, flush
// and occupancy status of aged_req_queue into one interface.
// Ports (signals):
//   in_valid/in_ready/in_op/in_addr     upstream request handshake
//   out_valid/out_ready/out_op/out_addr downstream issue handshake
//   flush                               discard all queued entries
//   count/full/empty                    occupancy status
// Modports: master = request producer / consumer side, slave = the queue.
interface aged_req_queue_if #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 33,
    parameter int OP_W   = 2
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic              in_valid;
    logic              in_ready;
    logic [OP_W-1:0]   in_op;
    logic [ADDR_W-1:0] in_addr;
    logic              out_valid;
    logic              out_ready;
    logic [OP_W-1:0]   out_op;
    logic [ADDR_W-1:0] out_addr;
    logic              flush;
    logic [CNT_W-1:0]  count;
    logic              full;
    logic              empty;

    modport master (
        output in_valid, in_op, in_addr, out_ready, flush,
        input  in_ready, out_valid, out_op, out_addr, count, full, empty
    );

    modport slave (
        input  in_valid, in_op, in_addr, out_ready, flush,
        output in_ready, out_valid, out_op, out_addr, count, full, empty
    );
endinterface

// File: rtl/aged_req_queue.sv
// rtl/aged_req_queue.sv - FIFO that releases each request only after MIN_AGE cycles
//
// Purpose: holds (opcode, address) requests in arrival order and offers the
// head downstream once it has aged MIN_AGE cycles. Backpressures when full.
// Ports:
//   CPU_clk  clock, rising edge
//   rst      synchronous active-high reset
//   bus      aged_req_queue_if.slave: request in, aged request out,
//            flush, count/full/empty status
module aged_req_queue #(
    parameter  int DEPTH   = 16,
    parameter  int MIN_AGE = 100,
    parameter  int ADDR_W  = 33,
    parameter  int OP_W    = 2,
    localparam int AGE_W   = (MIN_AGE < 1) ? 1 : $clog2(MIN_AGE + 1),
    localparam int CNT_W   = $clog2(DEPTH + 1)
) (
    input logic             CPU_clk,
    input logic             rst,
    aged_req_queue_if.slave bus
);
    localparam int               PTR_W    = $clog2(DEPTH);
    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(DEPTH - 1);
    localparam logic [AGE_W-1:0] AGE_MAX  = AGE_W'(MIN_AGE);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    logic [DEPTH-1:0]  valid_q, valid_d;
    logic [AGE_W-1:0]  age_q [DEPTH];
    logic [AGE_W-1:0]  age_d [DEPTH];
    logic [OP_W-1:0]   op_q  [DEPTH];
    logic [ADDR_W-1:0] addr_q[DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;

    logic full_w, empty_w, out_valid_w, push, pop;

    // Status comes only from registered state, so in_valid/out_ready never
    // reach full/empty/count/in_ready combinationally.
    assign full_w      = (count_q == CNT_FULL);
    assign empty_w     = (count_q == '0);
    assign out_valid_w = !empty_w && valid_q[rd_ptr_q] && (age_q[rd_ptr_q] == AGE_MAX);
    assign push        = bus.in_valid && !full_w;
    assign pop         = out_valid_w && bus.out_ready;

    assign bus.in_ready  = !full_w;
    assign bus.full      = full_w;
    assign bus.empty     = empty_w;
    assign bus.count     = count_q;
    assign bus.out_valid = out_valid_w;
    assign bus.out_op    = out_valid_w ? op_q[rd_ptr_q]   : '0;
    assign bus.out_addr  = out_valid_w ? addr_q[rd_ptr_q] : '0;

    always_comb begin
        valid_d  = valid_q;
        age_d    = age_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (bus.flush) begin
            // Flush wins over any push or pop requested in the same cycle.
            valid_d  = '0;
            for (int i = 0; i < DEPTH; i++) begin
                age_d[i] = '0;
            end
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            // Ages saturate at MIN_AGE so a stalled head never wraps back
            // to ineligible.
            for (int i = 0; i < DEPTH; i++) begin
                if (valid_q[i] && (age_q[i] != AGE_MAX)) begin
                    age_d[i] = age_q[i] + 1'b1;
                end
            end
            if (pop) begin
                valid_d[rd_ptr_q] = 1'b0;
                age_d[rd_ptr_q]   = '0;
                rd_ptr_d          = (rd_ptr_q == LAST_IDX) ? '0 : rd_ptr_q + 1'b1;
            end
            // A push can only target the popped slot when the queue was full,
            // and no push is accepted then, so push after pop is safe.
            if (push) begin
                valid_d[wr_ptr_q] = 1'b1;
                age_d[wr_ptr_q]   = '0;
                wr_ptr_d          = (wr_ptr_q == LAST_IDX) ? '0 : wr_ptr_q + 1'b1;
            end
            if (push && !pop) begin
                count_d = count_q + 1'b1;
            end else if (pop && !push) begin
                count_d = count_q - 1'b1;
            end
        end
    end

    always_ff @(posedge CPU_clk) begin
        if (rst) begin
            valid_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                age_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            valid_q  <= valid_d;
            age_q    <= age_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload storage needs no reset: it is only visible behind valid_q.
    always_ff @(posedge CPU_clk) begin
        if (push && !bus.flush) begin
            op_q[wr_ptr_q]   <= bus.in_op;
            addr_q[wr_ptr_q] <= bus.in_addr;
        end
    end

    a_no_push_full: assert property (@(posedge CPU_clk) disable iff (rst) !(push && full_w));
    a_count_bound:  assert property (@(posedge CPU_clk) count_q <= CNT_FULL);
    a_pop_aged:     assert property (@(posedge CPU_clk) disable iff (rst)
                                     pop |-> (age_q[rd_ptr_q] == AGE_MAX));
endmodule

// File: tb/tb_aged_req_queue.sv
// tb/tb_aged_req_queue.sv - self-checking bench for aged_req_queue
module tb_aged_req_queue;
    localparam int D  = 4;
    localparam int MA = 3;
    localparam int AW = 33;
    localparam int OW = 2;
    localparam int VW = 1 + OW + AW + 3 + 3;

    typedef struct packed {
        logic [OW-1:0] op;
        logic [AW-1:0] addr;
        int            t;
    } ent_t;

    localparam logic [VW-1:0] RST_VEC = {1'b0, {OW{1'b0}}, {AW{1'b0}}, 3'd0, 1'b0, 1'b1, 1'b1};

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   edge_n = 0;
    ent_t ma[$];
    ent_t mz[$];

    always #5 clk = ~clk;

    aged_req_queue_if #(.DEPTH(D), .ADDR_W(AW), .OP_W(OW)) qa();
    aged_req_queue_if #(.DEPTH(D), .ADDR_W(AW), .OP_W(OW)) qz();

    aged_req_queue #(.DEPTH(D), .MIN_AGE(MA), .ADDR_W(AW), .OP_W(OW)) dut_a (
        .CPU_clk(clk), .rst(rst), .bus(qa.slave));
    aged_req_queue #(.DEPTH(D), .MIN_AGE(0), .ADDR_W(AW), .OP_W(OW)) dut_z (
        .CPU_clk(clk), .rst(rst), .bus(qz.slave));

    // Reference: an entry pushed at edge t is offered once edge t+age has
    // passed, if it is at the front of the queue.
    function automatic logic [VW-1:0] exp_vec(input int n, input ent_t h, input int age);
        logic ov;
        ov = (n > 0) && (edge_n >= h.t + age);
        return {ov, ov ? h.op : OW'(0), ov ? h.addr : AW'(0), 3'(n),
                (n == D), (n == 0), (n < D)};
    endfunction

    function automatic logic [VW-1:0] exp_a();
        ent_t h;
        h = '0;
        if (ma.size() > 0) h = ma[0];
        return exp_vec(ma.size(), h, MA);
    endfunction

    function automatic logic [VW-1:0] exp_z();
        ent_t h;
        h = '0;
        if (mz.size() > 0) h = mz[0];
        return exp_vec(mz.size(), h, 0);
    endfunction

    function automatic logic [VW-1:0] obs_a();
        return {qa.out_valid, qa.out_op, qa.out_addr, qa.count, qa.full, qa.empty, qa.in_ready};
    endfunction

    function automatic logic [VW-1:0] obs_z();
        return {qz.out_valid, qz.out_op, qz.out_addr, qz.count, qz.full, qz.empty, qz.in_ready};
    endfunction

    task automatic set_a(input logic v, input logic rdy, input logic fl);
        qa.in_valid  = v;
        qa.out_ready = rdy;
        qa.flush     = fl;
        qa.in_op     = OW'($urandom);
        qa.in_addr   = AW'({$urandom, $urandom});
    endtask

    task automatic set_z(input logic v, input logic rdy, input logic fl);
        qz.in_valid  = v;
        qz.out_ready = rdy;
        qz.flush     = fl;
        qz.in_op     = OW'($urandom);
        qz.in_addr   = AW'({$urandom, $urandom});
    endtask

    // Advance one clock and update both reference queues.
    task automatic tick();
        logic [VW-1:0] xa, xz;
        logic pa, ppa, pz, ppz, fa, fz, r;
        ent_t ea, ez;
        xa  = exp_a();
        xz  = exp_z();
        r   = rst;
        fa  = qa.flush;
        fz  = qz.flush;
        pa  = qa.in_valid && xa[0];
        ppa = xa[VW-1] && qa.out_ready;
        pz  = qz.in_valid && xz[0];
        ppz = xz[VW-1] && qz.out_ready;
        ea  = '{op: qa.in_op, addr: qa.in_addr, t: edge_n + 1};
        ez  = '{op: qz.in_op, addr: qz.in_addr, t: edge_n + 1};
        @(posedge clk);
        edge_n++;
        if (r) begin
            ma.delete();
            mz.delete();
        end else begin
            if (fa) ma.delete();
            else begin
                if (ppa) void'(ma.pop_front());
                if (pa) ma.push_back(ea);
            end
            if (fz) mz.delete();
            else begin
                if (ppz) void'(mz.pop_front());
                if (pz) mz.push_back(ez);
            end
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        set_a(1'b0, 1'b0, 1'b0);
        set_z(1'b0, 1'b0, 1'b0);
        tick();
        tick();
        checks++;
        if (obs_a() !== RST_VEC) begin
            errors++;
            $display("FAIL reset_a got %h exp %h", obs_a(), RST_VEC);
        end
        checks++;
        if (obs_z() !== RST_VEC) begin
            errors++;
            $display("FAIL reset_z got %h exp %h", obs_z(), RST_VEC);
        end
        rst = 1'b0;
        tick();
        checks++;
        if (obs_a() !== RST_VEC) begin
            errors++;
            $display("FAIL reset_idle got %h exp %h", obs_a(), RST_VEC);
        end
    endtask

    task automatic test_basic();
        set_a(1'b1, 1'b1, 1'b0);
        qa.in_op   = 2'd1;
        qa.in_addr = 33'h100;
        tick();
        qa.in_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (obs_a() !== exp_a()) begin
                errors++;
                $display("FAIL basic cyc %0d got %h exp %h", i, obs_a(), exp_a());
            end
            if (i == 3) begin
                checks++;
                if ({qa.out_valid, qa.out_addr} !== {1'b1, 33'h100}) begin
                    errors++;
                    $display("FAIL basic_latency got %b/%h exp 1/100", qa.out_valid, qa.out_addr);
                end
            end
            if (i == 4) begin
                checks++;
                if ({qa.count, qa.empty} !== {3'd0, 1'b1}) begin
                    errors++;
                    $display("FAIL basic_pop count %0d empty %b exp 0/1", qa.count, qa.empty);
                end
            end
            tick();
        end
    endtask

    task automatic test_full();
        for (int i = 0; i < 4; i++) begin
            set_a(1'b1, 1'b0, 1'b0);
            tick();
            checks++;
            if (obs_a() !== exp_a()) begin
                errors++;
                $display("FAIL full_fill cyc %0d got %h exp %h", i, obs_a(), exp_a());
            end
        end
        checks++;
        if ({qa.full, qa.in_ready, qa.count} !== {1'b1, 1'b0, 3'd4}) begin
            errors++;
            $display("FAIL full_flags got %b%b %0d exp 10 4", qa.full, qa.in_ready, qa.count);
        end
        set_a(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (obs_a() !== exp_a()) begin
                errors++;
                $display("FAIL full_reject cyc %0d got %h exp %h", i, obs_a(), exp_a());
            end
        end
        set_a(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++;
            if (obs_a() !== exp_a()) begin
                errors++;
                $display("FAIL full_drain cyc %0d got %h exp %h", i, obs_a(), exp_a());
            end
        end
    endtask

    task automatic test_wrap();
        int pushed;
        pushed = 0;
        for (int i = 0; i < 30; i++) begin
            set_a((pushed < 6) && ($urandom_range(0, 2) != 0), 1'($urandom), 1'b0);
            if (qa.in_valid && exp_a() != '0 && qa.count < 3'(D)) pushed++;
            tick();
            checks++;
            if (obs_a() !== exp_a()) begin
                errors++;
                $display("FAIL wrap cyc %0d got %h exp %h", i, obs_a(), exp_a());
            end
        end
        set_a(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if (obs_a() !== exp_a()) begin
                errors++;
                $display("FAIL wrap_drain cyc %0d got %h exp %h", i, obs_a(), exp_a());
            end
        end
    endtask

    task automatic test_stall();
        for (int i = 0; i < 3; i++) begin
            set_a(1'b1, 1'b0, 1'b0);
            tick();
        end
        set_a(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < MA + 10; i++) begin
            tick();
            checks++;
            if (obs_a() !== exp_a()) begin
                errors++;
                $display("FAIL stall cyc %0d got %h exp %h", i, obs_a(), exp_a());
            end
        end
        checks++;
        if (qa.out_valid !== 1'b1) begin
            errors++;
            $display("FAIL stall_hold out_valid %b exp 1", qa.out_valid);
        end
        set_a(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (obs_a() !== exp_a()) begin
                errors++;
                $display("FAIL stall_release cyc %0d got %h exp %h", i, obs_a(), exp_a());
            end
        end
    endtask

    task automatic test_flush();
        for (int i = 0; i < 3; i++) begin
            set_a(1'b1, 1'b0, 1'b0);
            tick();
        end
        checks++;
        if (qa.count !== 3'd3) begin
            errors++;
            $display("FAIL flush_pre count %0d exp 3", qa.count);
        end
        set_a(1'b1, 1'b1, 1'b1);
        tick();
        set_a(1'b0, 1'b1, 1'b0);
        checks++;
        if ({qa.count, qa.empty, qa.out_valid} !== {3'd0, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL flush_clear got %0d/%b/%b exp 0/1/0", qa.count, qa.empty, qa.out_valid);
        end
        for (int i = 0; i < 8; i++) begin
            tick();
            checks++;
            if (obs_a() !== exp_a()) begin
                errors++;
                $display("FAIL flush_after cyc %0d got %h exp %h", i, obs_a(), exp_a());
            end
        end
    endtask

    task automatic test_zero_age();
        logic [AW-1:0] a0;
        set_z(1'b1, 1'b0, 1'b0);
        a0 = qz.in_addr;
        tick();
        checks++;
        if ({qz.out_valid, qz.out_addr} !== {1'b1, a0}) begin
            errors++;
            $display("FAIL zero_latency got %b/%h exp 1/%h", qz.out_valid, qz.out_addr, a0);
        end
        for (int i = 0; i < 8; i++) begin
            set_z(1'b1, 1'b1, 1'b0);
            tick();
            checks++;
            if (obs_z() !== exp_z() || qz.count !== 3'd1) begin
                errors++;
                $display("FAIL zero_pushpop cyc %0d got %h exp %h", i, obs_z(), exp_z());
            end
        end
        set_z(1'b0, 1'b1, 1'b0);
        tick();
        checks++;
        if (obs_z() !== exp_z()) begin
            errors++;
            $display("FAIL zero_drain got %h exp %h", obs_z(), exp_z());
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 500; i++) begin
            set_a(1'($urandom), 1'($urandom), $urandom_range(0, 39) == 0);
            set_z(1'($urandom), $urandom_range(0, 3) == 0, $urandom_range(0, 39) == 0);
            rst = ($urandom_range(0, 99) == 0);
            tick();
            checks++;
            if (obs_a() !== exp_a()) begin
                errors++;
                $display("FAIL random_a cyc %0d got %h exp %h", i, obs_a(), exp_a());
            end
            checks++;
            if (obs_z() !== exp_z()) begin
                errors++;
                $display("FAIL random_z cyc %0d got %h exp %h", i, obs_z(), exp_z());
            end
        end
        rst = 1'b0;
        set_z(1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) begin
            set_a(1'b1, 1'b0, 1'b0);
            tick();
        end
        for (int i = 0; i < MA; i++) begin
            set_a(1'b0, 1'b0, 1'b0);
            tick();
        end
        set_a(1'b1, 1'b1, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        set_a(1'b0, 1'b1, 1'b0);
        checks++;
        if (obs_a() !== RST_VEC) begin
            errors++;
            $display("FAIL reset_mid got %h exp %h", obs_a(), RST_VEC);
        end
        for (int i = 0; i < MA + 2; i++) begin
            tick();
            checks++;
            if (obs_a() !== RST_VEC) begin
                errors++;
                $display("FAIL reset_mid_quiet cyc %0d got %h exp %h", i, obs_a(), RST_VEC);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_full();
        test_wrap();
        test_stall();
        test_flush();
        test_zero_age();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
